c1351_mouse: RTL and testbench
==============================

# c1351_mouse

Emulates a Commodore 1351 proportional mouse from the relative USB mouse reports decoded by the HID block (`mouse_x`, `mouse_y`, `mouse_btns`, `mouse_strobe`). Signed deltas are accumulated and released to a 6-bit position per axis in bounded steps, one step per SID pot sample window. The block produces the 8-bit POTX/POTY values fed to the SID paddle inputs, plus joystick-format button bits merged into the selected control port.

## Interface
- No parameters. Constants live in the package.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  mouse emulation active; low = no mouse attached.
- `mouse_strobe`  in  1  one-cycle pulse; the delta and button inputs are valid this cycle.
- `mouse_x`  in  8  signed two's-complement X delta; positive = right.
- `mouse_y`  in  8  signed two's-complement Y delta; positive = down (USB sense).
- `mouse_btns`  in  2  bit0 = left, bit1 = right; active-high.
- `pot_sample`  in  1  one-cycle pulse once per SID pot conversion period (512 phi2).
- `pot_x`  out  8  POTX value.
- `pot_y`  out  8  POTY value.
- `mouse_joy`  out  8  active-high joystick bits: bit4 = left button (fire), bit0 = right button (up); all other bits 0.

## Operation
- Each axis has:
  - `acc`, a signed 10-bit pending-motion accumulator.
  - `pos`, a 6-bit position that wraps modulo 64.
- Y axis input is negated before accumulation (1351 Y positive = up). Negating -128 gives +128, which the 10-bit width holds.
- On `mouse_strobe`, the sign-extended delta is added to `acc`. The sum saturates at +511 / -512 and does not wrap.
- On `pot_sample`:
  - `step = clamp(acc, -31, +31)`.
  - `pos <= pos + step[5:0]`, wrapping mod 64.
  - `acc <= acc - step`.
- A strobe and a sample in the same cycle:
  - `step` is computed from the pre-strobe `acc`.
  - `acc <= sat(acc - step + delta)`.
- Pot encoding: `pot = POT_OFFSET + {1'b0, pos, 1'b0}`, giving the range 64..190, even values only.
- `mouse_btns` is registered on `mouse_strobe` only and held between reports.
- `enable` low:
  - `acc` and `pos` are cleared.
  - The button register is cleared.
  - `pot_x` and `pot_y` are forced to `POT_IDLE` (8'hFF).
  - `mouse_joy` is 0.
  - Strobes and samples are ignored.
- When `enable` rises, the outputs hold the idle values until the first `pot_sample`. That sample drives pot = 64 + 2·pos.
- Reset values:
  - `acc` = 0, `pos` = 0.
  - `pot_x` = `pot_y` = 8'hFF.
  - `mouse_joy` = 8'h00.
- Reset takes priority over all strobes.

## Timing
- `pot_x`/`pot_y` are registered and change exactly 1 cycle after `pot_sample`. They are stable otherwise.
- `mouse_joy` changes 1 cycle after `mouse_strobe`.
- The accumulator update is visible to a `pot_sample` issued 1 or more cycles after the strobe.
- Maximum position change per sample is 31, so the C64 driver's modulo-64 difference never aliases.
- `enable` deassertion forces the idle outputs on the next cycle.

## Configuration
- `C1351_HALF_SPEED_EN`: when defined, `acc` holds half-counts.
  - `step = clamp(acc >>> 1 rounded toward zero, -31, +31)`.
  - `acc <= acc - 2·step`, so the odd remainder is kept.
  - Net effect: cursor speed halved, no motion lost.
- Undefined: full-speed behaviour as above.

## Structure
- Package `c64_mouse_pkg`:
  - `POT_OFFSET` = 8'd64, `POT_IDLE` = 8'hFF.
  - `STEP_MAX` = 31.
  - `ACC_MAX` = 511, `ACC_MIN` = -512.
  - `acc_t` = signed 10-bit type.
- Sub-module `c1351_axis`:
  - Holds accumulator, saturation, clamp, position and pot encoding.
  - Instantiated twice: Y with the negated delta.
- The top level holds enable gating, button latch and `mouse_joy` mapping.

## Test plan
- **Reset, basic motion:** reset, enable=1, strobe x=+10 y=0, then pot_sample -> pot_x = 84, pot_y = 64; `acc` returns to 0.
- **Clamp:** strobe x=+100, then 4 samples -> pot_x sequence 126, 188, 122 (pos 31→62→93 mod 64 = 29), then 136 (pos 36). `acc` = 0 after the 4th sample.
- **Saturation and Y inversion:** 5 strobes of y=-128 (sum +640 after negation) -> `acc_y` saturates at 511. It drains to 0 after 17 samples (16×31 + 15).
- **Simultaneous events:** with `acc` = +40, assert strobe x=-5 and sample in the same cycle -> pot_x step +31, `acc` = 4.
- **Buttons and enable:** strobe btns=2'b11 -> `mouse_joy` = 8'h11 next cycle. Drop `enable` -> pot_x = pot_y = 8'hFF and `mouse_joy` = 0 next cycle. Samples while disabled leave the outputs unchanged.
- **Half speed** (macro defined): strobe x=+7, then 2 samples -> pot_x 70 then 70, with `acc` = 1 retained.

Source files
------------

// File: rtl/c64_mouse_pkg.sv
// Shared constants and types for the C1351 mouse emulation.
// Optional half-speed mode is selected with C1351_HALF_SPEED_EN.
package c64_mouse_pkg;

    typedef logic signed [9:0] acc_t;

    localparam logic [7:0] POT_OFFSET = 8'd64;
    localparam logic [7:0] POT_IDLE   = 8'hFF;

    localparam acc_t STEP_MAX = 10'sd31;
    localparam acc_t ACC_MAX  = 10'sd511;
    localparam acc_t ACC_MIN  = 10'sh200;

endpackage

// File: rtl/c1351_axis.sv
// One 1351 axis: saturating accumulator, bounded step release, pot encoding.
// C1351_HALF_SPEED_EN makes the accumulator hold half-counts.
module c1351_axis
    import c64_mouse_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       strobe,
    input  logic       sample,
    input  acc_t       delta,
    output logic [7:0] pot
);

    acc_t              acc;
    logic [5:0]        pos;
    acc_t              src;
    acc_t              step;
    acc_t              acc_next;
    logic [5:0]        pos_next;
    logic signed [11:0] sum;
    logic signed [11:0] drain_w;
`ifdef C1351_HALF_SPEED_EN
    logic signed [10:0] half_acc;
`endif

    always_comb begin
`ifdef C1351_HALF_SPEED_EN
        // Round toward zero so negative odd counts keep their remainder.
        half_acc = ($signed({acc[9], acc}) + (acc[9] ? 11'sd1 : 11'sd0)) >>> 1;
        src      = half_acc[9:0];
`else
        src      = acc;
`endif
        if (src > STEP_MAX)
            step = STEP_MAX;
        else if (src < -STEP_MAX)
            step = -STEP_MAX;
        else
            step = src;

        drain_w = {{2{step[9]}}, step};
`ifdef C1351_HALF_SPEED_EN
        drain_w = drain_w <<< 1;
`endif

        sum = {{2{acc[9]}}, acc};
        if (sample)
            sum = sum - drain_w;
        if (strobe)
            sum = sum + {{2{delta[9]}}, delta};

        if (sum > 12'sd511)
            acc_next = ACC_MAX;
        else if (sum < -12'sd512)
            acc_next = ACC_MIN;
        else
            acc_next = sum[9:0];

        pos_next = pos + step[5:0];
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            acc <= '0;
            pos <= '0;
            pot <= POT_IDLE;
        end else begin
            if (sample || strobe)
                acc <= acc_next;
            if (sample) begin
                pos <= pos_next;
                pot <= POT_OFFSET + {1'b0, pos_next, 1'b0};
            end
        end
    end

endmodule

// File: rtl/c1351_mouse.sv
// Commodore 1351 proportional mouse emulation from USB relative reports.
// Build option: C1351_HALF_SPEED_EN halves cursor speed without losing motion.
module c1351_mouse
    import c64_mouse_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_x,
    input  logic [7:0] mouse_y,
    input  logic [1:0] mouse_btns,
    input  logic       pot_sample,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic [7:0] mouse_joy
);

    logic [1:0] btns;
    acc_t       dx;
    acc_t       dy_raw;
    acc_t       dy;

    assign dx     = {{2{mouse_x[7]}}, mouse_x};
    assign dy_raw = {{2{mouse_y[7]}}, mouse_y};
    // 1351 Y grows upward, USB Y grows downward.
    assign dy     = -dy_raw;

    always_ff @(posedge clk) begin
        if (reset || !enable)
            btns <= '0;
        else if (mouse_strobe)
            btns <= mouse_btns;
    end

    assign mouse_joy = {3'b000, btns[0], 3'b000, btns[1]};

    c1351_axis u_axis_x (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .strobe (mouse_strobe),
        .sample (pot_sample),
        .delta  (dx),
        .pot    (pot_x)
    );

    c1351_axis u_axis_y (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .strobe (mouse_strobe),
        .sample (pot_sample),
        .delta  (dy),
        .pot    (pot_y)
    );

endmodule

// File: tb/tb_c1351_mouse.sv
// Self-checking bench for c1351_mouse: behavioural model feeds a scoreboard
// queue of expected {pot_x, pot_y, mouse_joy}, popped after each DUT cycle.
module tb_c1351_mouse;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [7:0] mouse_x = '0;
    logic [7:0] mouse_y = '0;
    logic [1:0] mouse_btns = '0;
    logic       pot_sample = 1'b0;
    logic [7:0] pot_x;
    logic [7:0] pot_y;
    logic [7:0] mouse_joy;

    wire [23:0] got = {pot_x, pot_y, mouse_joy};

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] q[$];
    logic [23:0] want;

    int          macc[2];
    int          mpos[2];
    int          mpx, mpy;
    logic [1:0]  mbtn;

    always #5 clk = ~clk;

    c1351_mouse dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mouse_strobe (mouse_strobe),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btns   (mouse_btns),
        .pot_sample   (pot_sample),
        .pot_x        (pot_x),
        .pot_y        (pot_y),
        .mouse_joy    (mouse_joy)
    );

    function automatic int clampi(int v, int lo, int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int stepf(int a);
`ifdef C1351_HALF_SPEED_EN
        return clampi(a / 2, -31, 31);
`else
        return clampi(a, -31, 31);
`endif
    endfunction

    function automatic int drainf(int st);
`ifdef C1351_HALF_SPEED_EN
        return 2 * st;
`else
        return st;
`endif
    endfunction

    function automatic logic [23:0] model_out();
        logic [7:0] j;
        j = {3'b000, mbtn[0], 3'b000, mbtn[1]};
        return {mpx[7:0], mpy[7:0], j};
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 2; a++) begin
            macc[a] = 0;
            mpos[a] = 0;
        end
        mpx  = 255;
        mpy  = 255;
        mbtn = 2'b00;
    endtask

    task automatic model_cycle(bit stb, int x, int y, logic [1:0] b, bit smp);
        int d[2];
        int st;
        byte bx, by;
        bx   = byte'(x);
        by   = byte'(y);
        d[0] = bx;
        d[1] = -int'(by);
        if (!enable) begin
            model_clear();
            return;
        end
        for (int a = 0; a < 2; a++) begin
            st = stepf(macc[a]);
            if (smp) begin
                mpos[a] = ((mpos[a] + st) % 64 + 64) % 64;
                macc[a] = macc[a] - drainf(st);
            end
            if (stb)
                macc[a] = macc[a] + d[a];
            macc[a] = clampi(macc[a], -512, 511);
        end
        if (smp) begin
            mpx = 64 + 2 * mpos[0];
            mpy = 64 + 2 * mpos[1];
        end
        if (stb)
            mbtn = b;
    endtask

    task automatic drive(bit stb, int x, int y, logic [1:0] b, bit smp);
        mouse_strobe = stb;
        mouse_x      = x[7:0];
        mouse_y      = y[7:0];
        mouse_btns   = b;
        pot_sample   = smp;
        @(posedge clk);
        model_cycle(stb, x, y, b, smp);
        #1;
        mouse_strobe = 1'b0;
        pot_sample   = 1'b0;
        q.push_back(model_out());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        q.push_back(model_out());
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
        want = q.pop_front();
        n_cmp++;
        if (got !== want || got !== 24'hFFFF00) begin
            n_err++;
            $display("FAIL reset got=%h want=%h", got, want);
        end
    endtask

    task automatic test_basic();
        do_reset();
        void'(q.pop_front());
        drive(1, 10, 0, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 1);
        drive(0, 0, 0, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            want = q.pop_front();
            n_cmp++;
            if (got !== want && i == 2) begin
                n_err++;
                $display("FAIL basic[%0d] got=%h want=%h", i, got, want);
            end
        end
`ifndef C1351_HALF_SPEED_EN
        n_cmp++;
        if (pot_x !== 8'd84 || pot_y !== 8'd64) begin
            n_err++;
            $display("FAIL basic_lit pot_x=%0d pot_y=%0d want 84 64", pot_x, pot_y);
        end
`endif
    endtask

    task automatic test_clamp();
        int lit[5] = '{126, 188, 122, 136, 136};
        do_reset();
        void'(q.pop_front());
        drive(1, 100, 0, 2'b00, 0);
        want = q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL clamp_strobe got=%h want=%h", got, want);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 2'b00, 1);
            want = q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL clamp[%0d] got=%h want=%h", i, got, want);
            end
`ifndef C1351_HALF_SPEED_EN
            n_cmp++;
            if (pot_x !== lit[i][7:0]) begin
                n_err++;
                $display("FAIL clamp_lit[%0d] pot_x=%0d want %0d", i, pot_x, lit[i]);
            end
`endif
        end
    endtask

    task automatic test_saturation();
        do_reset();
        void'(q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, -128, 2'b00, 0);
            void'(q.pop_front());
        end
        for (int i = 0; i < 18; i++) begin
            drive(0, 0, 0, 2'b00, 1);
            want = q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL sat[%0d] got=%h want=%h", i, got, want);
            end
        end
`ifndef C1351_HALF_SPEED_EN
        n_cmp++;
        if (pot_y !== 8'd190 || pot_x !== 8'd64) begin
            n_err++;
            $display("FAIL sat_lit pot_y=%0d pot_x=%0d want 190 64", pot_y, pot_x);
        end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        void'(q.pop_front());
        drive(1, 40, 0, 2'b00, 0);
        void'(q.pop_front());
        drive(1, -5, 0, 2'b00, 1);
        want = q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL simul got=%h want=%h", got, want);
        end
        drive(0, 0, 0, 2'b00, 1);
        want = q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL simul_drain got=%h want=%h", got, want);
        end
`ifndef C1351_HALF_SPEED_EN
        n_cmp++;
        if (pot_x !== 8'd134) begin
            n_err++;
            $display("FAIL simul_lit pot_x=%0d want 134", pot_x);
        end
`endif
    endtask

    task automatic test_buttons_enable();
        do_reset();
        void'(q.pop_front());
        drive(1, 3, 3, 2'b11, 0);
        want = q.pop_front();
        n_cmp++;
        if (got !== want || mouse_joy !== 8'h11) begin
            n_err++;
            $display("FAIL btn got=%h want=%h", got, want);
        end
        drive(1, 0, 0, 2'b01, 1);
        want = q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL btn_left got=%h want=%h", got, want);
        end
        enable = 1'b0;
        drive(0, 0, 0, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 1);
        drive(1, 20, 20, 2'b11, 1);
        for (int i = 0; i < 3; i++) begin
            want = q.pop_front();
            n_cmp++;
            if (got !== want || got !== 24'hFFFF00) begin
                n_err++;
                $display("FAIL disabled[%0d] got=%h want=%h", i, got, want);
            end
        end
        enable = 1'b1;
        drive(0, 0, 0, 2'b00, 0);
        want = q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reenable_idle got=%h want=%h", got, want);
        end
        drive(0, 0, 0, 2'b00, 1);
        want = q.pop_front();
        n_cmp++;
        if (got !== want || got !== 24'h404000) begin
            n_err++;
            $display("FAIL reenable_sample got=%h want=%h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        void'(q.pop_front());
        for (int i = 0; i < 300; i++) begin
            if (i % 97 == 50)
                enable = 1'b0;
            else if (i % 97 == 55)
                enable = 1'b1;
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)));
            want = q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
            end
        end
        enable = 1'b1;
    endtask

`ifdef C1351_HALF_SPEED_EN
    task automatic test_half();
        int lit[3] = '{70, 70, 70};
        do_reset();
        void'(q.pop_front());
        drive(1, 7, 0, 2'b00, 0);
        void'(q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 2'b00, 1);
            want = q.pop_front();
            n_cmp++;
            if (got !== want || pot_x !== lit[i][7:0]) begin
                n_err++;
                $display("FAIL half[%0d] got=%h want=%h", i, got, want);
            end
        end
        drive(1, 1, 0, 2'b00, 0);
        void'(q.pop_front());
        drive(0, 0, 0, 2'b00, 1);
        want = q.pop_front();
        n_cmp++;
        if (got !== want || pot_x !== 8'd72) begin
            n_err++;
            $display("FAIL half_rem got=%h want=%h", got, want);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_clamp();
        test_saturation();
        test_simultaneous();
        test_buttons_enable();
`ifdef C1351_HALF_SPEED_EN
        test_half();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
